// File: rtl/scrambler_ctrl.sv
// scrambler_ctrl: sequences PR-generator load, warm-up and per-bit scrambling for one codeword.
// Define SCC_TIMEOUT_EN to add an 11-bit warm-up watchdog that pulses SCC_ERR.
module scrambler_ctrl (
  input  logic        CLK_SCC,
  input  logic        RST_SCC,
  input  logic        START_SCC,
  input  logic [15:0] N_RNTI,
  input  logic [9:0]  N_ID,
  input  logic [15:0] E_LEN,
  input  logic        IL_VALID,
  input  logic        GOLD_VALID,
  output logic [30:0] C_INIT,
  output logic        GEN_INIT,
  output logic        GEN_EN,
  output logic        SC_EN,
  output logic        SC_BUSY,
  output logic        IL_READY,
  output logic        SCC_DONE,
  output logic        SCC_ERR
);
  typedef enum logic [2:0] {IDLE, LOAD, WARMUP, RUN, DONE} state_t;
  state_t state, next_state;
  logic [15:0] len_q, cnt;
  logic accept, last, timeout;
  assign accept = state == RUN && IL_VALID && GOLD_VALID;
  assign last = cnt == len_q - 16'd1;
`ifdef SCC_TIMEOUT_EN
  logic [10:0] wd;
  logic err_q;
  // 2047th consecutive warm-up cycle without GOLD_VALID
  assign timeout = state == WARMUP && !GOLD_VALID && wd == 11'd2046;
  always_ff @(posedge CLK_SCC) begin
    if (RST_SCC) begin
      wd <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= state == WARMUP ? wd + 11'd1 : '0;
      err_q <= timeout;
    end
  end
  assign SCC_ERR = err_q;
`else
  assign timeout = 1'b0;
  assign SCC_ERR = 1'b0;
`endif
  always_ff @(posedge CLK_SCC) begin
    if (RST_SCC) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge CLK_SCC) begin
    if (RST_SCC) begin
      C_INIT <= '0;
      len_q <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && START_SCC && E_LEN != '0) begin
        C_INIT <= {N_RNTI, 15'b0} + 31'(N_ID);
        len_q <= E_LEN;
      end
      cnt <= state == RUN ? cnt + 16'(accept) : '0;
    end
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = START_SCC && E_LEN != '0 ? LOAD : IDLE;
      LOAD:    next_state = WARMUP;
      WARMUP:  next_state = GOLD_VALID ? RUN : timeout ? IDLE : WARMUP;
      RUN:     next_state = accept && last ? DONE : RUN;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    GEN_INIT = state == LOAD;
    GEN_EN = state == WARMUP || accept;
    SC_EN = state == WARMUP || state == RUN;
    SC_BUSY = state == RUN;
    IL_READY = accept;
    SCC_DONE = state == DONE;
  end
endmodule

// File: tb/tb_scrambler_ctrl.sv
// tb_scrambler_ctrl: directed and randomized codewords checked against a transaction-level model.
module tb_scrambler_ctrl;
  logic        CLK_SCC = 1'b0;
  logic        RST_SCC, START_SCC, IL_VALID, GOLD_VALID;
  logic [15:0] N_RNTI, E_LEN;
  logic [9:0]  N_ID;
  logic [30:0] C_INIT;
  logic        GEN_INIT, GEN_EN, SC_EN, SC_BUSY, IL_READY, SCC_DONE, SCC_ERR;
  int checks = 0;
  int errors = 0;

  scrambler_ctrl dut (
    .CLK_SCC(CLK_SCC), .RST_SCC(RST_SCC), .START_SCC(START_SCC),
    .N_RNTI(N_RNTI), .N_ID(N_ID), .E_LEN(E_LEN),
    .IL_VALID(IL_VALID), .GOLD_VALID(GOLD_VALID),
    .C_INIT(C_INIT), .GEN_INIT(GEN_INIT), .GEN_EN(GEN_EN), .SC_EN(SC_EN),
    .SC_BUSY(SC_BUSY), .IL_READY(IL_READY), .SCC_DONE(SCC_DONE), .SCC_ERR(SCC_ERR)
  );

  always #5 CLK_SCC = ~CLK_SCC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string ph, input bit gi, ge, se, sb, ir, dn, er);
    chk({ph, ".GEN_INIT"}, 32'(GEN_INIT), 32'(gi));
    chk({ph, ".GEN_EN"}, 32'(GEN_EN), 32'(ge));
    chk({ph, ".SC_EN"}, 32'(SC_EN), 32'(se));
    chk({ph, ".SC_BUSY"}, 32'(SC_BUSY), 32'(sb));
    chk({ph, ".IL_READY"}, 32'(IL_READY), 32'(ir));
    chk({ph, ".SCC_DONE"}, 32'(SCC_DONE), 32'(dn));
    chk({ph, ".SCC_ERR"}, 32'(SCC_ERR), 32'(er));
  endtask

  task automatic cycle();
    @(negedge CLK_SCC);
    START_SCC = 1'b0;
    RST_SCC = 1'b0;
  endtask

  task automatic start_cw(input logic [15:0] rnti, input logic [9:0] id, input logic [15:0] len,
                          output logic [30:0] ci);
    ci = 31'(rnti) * 31'd32768 + 31'(id);
    cycle();
    START_SCC = 1'b1; N_RNTI = rnti; N_ID = id; E_LEN = len; IL_VALID = 1'b0; GOLD_VALID = 1'b0;
    #1 chk_out("idle_start", 0, 0, 0, 0, 0, 0, 0);
    cycle();
    N_RNTI = 16'($urandom); N_ID = 10'($urandom); E_LEN = 16'($urandom);
    #1 chk_out("load", 1, 0, 0, 0, 0, 0, 0);
    chk("c_init", 32'(C_INIT), 32'(ci));
  endtask

  // mode 0: valids held 1; mode 1: IL_VALID toggles; mode 2: random valids, stray STARTs, E_LEN churn
  task automatic codeword(input logic [15:0] rnti, input logic [9:0] id, input logic [15:0] len,
                          input int warm, input int mode, input int rst_after);
    logic [30:0] ci;
    int acc, n;
    bit iv, gv;
    start_cw(rnti, id, len, ci);
    for (int i = 0; i < warm; i++) begin
      cycle();
      GOLD_VALID = 1'b0; IL_VALID = 1'($urandom);
      #1 chk_out("warmup", 0, 1, 1, 0, 0, 0, 0);
    end
    cycle();
    GOLD_VALID = 1'b1; IL_VALID = 1'($urandom);
    #1 chk_out("warmup_go", 0, 1, 1, 0, 0, 0, 0);
    acc = 0;
    n = 0;
    while (acc < int'(len)) begin
      cycle();
      iv = mode == 0 ? 1'b1 : mode == 1 ? n % 2 == 0 : $urandom_range(3) != 0;
      gv = mode == 2 ? $urandom_range(3) != 0 : 1'b1;
      IL_VALID = iv; GOLD_VALID = gv;
      if (mode == 2) begin
        START_SCC = $urandom_range(3) == 0;
        E_LEN = 16'($urandom);
      end
      #1 chk_out("run", 0, iv & gv, 1, 1, iv & gv, 0, 0);
      if (mode != 0 || acc % 4096 == 0) chk("run.c_init", 32'(C_INIT), 32'(ci));
      acc += int'(iv & gv);
      n++;
      if (rst_after != 0 && acc == rst_after) begin
        cycle();
        RST_SCC = 1'b1; START_SCC = 1'b1; E_LEN = 16'd10; IL_VALID = 1'b0; GOLD_VALID = 1'b0;
        #1 chk_out("pre_rst", 0, 0, 1, 1, 0, 0, 0);
        cycle();
        #1 chk_out("post_rst", 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst.c_init", 32'(C_INIT), 32'd0);
        return;
      end
    end
    cycle();
    IL_VALID = 1'b0; GOLD_VALID = 1'b0;
    #1 chk_out("done", 0, 0, 0, 0, 0, 1, 0);
    cycle();
    #1 chk_out("idle_after", 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [30:0] ci;
    RST_SCC = 1'b1; START_SCC = 1'b0; N_RNTI = '0; N_ID = '0; E_LEN = '0;
    IL_VALID = 1'b0; GOLD_VALID = 1'b0;
    repeat (3) @(negedge CLK_SCC);
    #1 chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.c_init", 32'(C_INIT), 32'd0);
    cycle();
    #1 chk_out("idle", 0, 0, 0, 0, 0, 0, 0);
    codeword(16'h1234, 10'h03A, 16'd8, 5, 0, 0);
    chk("vec.c_init", 32'(C_INIT), 32'h091A003A);
    codeword(16'hBEEF, 10'h155, 16'd4, 2, 1, 0);
    cycle();
    START_SCC = 1'b1; E_LEN = 16'd0;
    #1 chk_out("zero_len", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1 chk_out("zero_len_idle", 0, 0, 0, 0, 0, 0, 0);
    end
    codeword(16'h0F0F, 10'h2AA, 16'd10, 1, 0, 3);
    codeword(16'h0F0F, 10'h2AA, 16'd10, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      codeword(16'($urandom), 10'($urandom), 16'($urandom_range(40, 1)), $urandom_range(6), 2, 0);
    codeword(16'hFFFF, 10'h3FF, 16'd1, 0, 2, 0);
    start_cw(16'h00A5, 10'h001, 16'd5, ci);
    for (int i = 0; i < 2047; i++) begin
      cycle();
      GOLD_VALID = 1'b0; IL_VALID = 1'b1;
      #1 chk_out("wd_warm", 0, 1, 1, 0, 0, 0, 0);
    end
`ifdef SCC_TIMEOUT_EN
    cycle();
    #1 chk_out("wd_err", 0, 0, 0, 0, 0, 0, 1);
    cycle();
    #1 chk_out("wd_idle", 0, 0, 0, 0, 0, 0, 0);
`else
    for (int i = 0; i < 20; i++) begin
      cycle();
      #1 chk_out("wd_hold", 0, 1, 1, 0, 0, 0, 0);
    end
    cycle();
    RST_SCC = 1'b1;
    cycle();
    #1 chk_out("wd_rst", 0, 0, 0, 0, 0, 0, 0);
`endif
    codeword(16'h5A5A, 10'h0C3, 16'd65535, 3, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scrambler_ctrl.md
SCRAMBLER_CTRL -- requirements
Module: scrambler_ctrl

Interface
REQ-001 SHALL have port CLK_SCC, input, 1, single clock; all logic on its rising edge.
REQ-002 SHALL have port RST_SCC, input, 1, synchronous active-high reset, sampled on CLK_SCC.
REQ-003 SHALL have port START_SCC, input, 1, one-cycle pulse requesting a codeword.
REQ-004 SHALL have port N_RNTI, input, 16, RNTI for c_init.
REQ-005 SHALL have port N_ID, input, 10, scrambling ID for c_init.
REQ-006 SHALL have port E_LEN, input, 16, codeword length in bits.
REQ-007 SHALL have port IL_VALID, input, 1, interleaver bit valid.
REQ-008 SHALL have port GOLD_VALID, input, 1, PR generator sequence valid.
REQ-009 SHALL have port C_INIT, output, 31, registered value {N_RNTI,15'b0}+N_ID for the PR generator.
REQ-010 SHALL have port GEN_INIT, output, 1, load pulse to the PR generator.
REQ-011 SHALL have port GEN_EN, output, 1, advance enable to the PR generator.
REQ-012 SHALL have port SC_EN, output, 1, drives the scrambler EN_SC.
REQ-013 SHALL have port SC_BUSY, output, 1, drives the scrambler SC_BUSY_IN.
REQ-014 SHALL have port IL_READY, output, 1, bit-accept strobe to the interleaver.
REQ-015 SHALL have port SCC_DONE, output, 1, one-cycle codeword-complete pulse.
REQ-016 SHALL have port SCC_ERR, output, 1, one-cycle warm-up timeout pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WARMUP, RUN, DONE.
REQ-018 IDLE: START_SCC=1 with E_LEN!=0 SHALL register C_INIT and E_LEN and go to LOAD; E_LEN=0 SHALL be ignored.
REQ-019 LOAD: GEN_INIT=1 for exactly this one cycle; next state WARMUP.
REQ-020 WARMUP: GEN_EN=1, SC_EN=1; GOLD_VALID=1 SHALL move to RUN next cycle.
REQ-021 RUN: SC_EN=1, SC_BUSY=1; IL_READY=GEN_EN=IL_VALID&GOLD_VALID, combinational.
REQ-022 RUN: 16-bit bit counter SHALL increment on each cycle with IL_VALID&GOLD_VALID; the accept at count E_LEN-1 SHALL move to DONE.
REQ-023 RUN: IL_VALID=0 SHALL hold counter and stall the PR generator (GEN_EN=0); no timeout applies.
REQ-024 DONE: SCC_DONE=1 for one cycle, SC_BUSY=0, SC_EN=0; next state IDLE.
REQ-025 START_SCC in any state other than IDLE SHALL be ignored.
REQ-026 Latency: START at cycle t -> GEN_INIT at t+1 -> WARMUP from t+2; DONE pulse one cycle after final accept.
REQ-027 E_LEN=65535 SHALL complete without counter wrap; registered E_LEN SHALL not change mid-codeword.

Reset
REQ-028 RST_SCC=1 SHALL force IDLE, counter 0, C_INIT 0, and all outputs 0 on the next edge, including mid-codeword.
REQ-029 Reset SHALL take priority over START_SCC in the same cycle.

Configuration
REQ-030 With SCC_TIMEOUT_EN defined, an 11-bit watchdog SHALL count WARMUP cycles; 2047 cycles without GOLD_VALID SHALL pulse SCC_ERR one cycle and return to IDLE (no SCC_DONE).
REQ-031 Without SCC_TIMEOUT_EN, WARMUP SHALL wait indefinitely and SCC_ERR SHALL be constant 0.

Verification
REQ-032 N_RNTI=16'h1234, N_ID=10'h3A, E_LEN=8, START; GOLD_VALID after 5 cycles, IL_VALID constant 1 -> C_INIT=31'h091A003A, one GEN_INIT, 8 IL_READY pulses, SCC_DONE 1 cycle after 8th.
REQ-033 E_LEN=4, IL_VALID toggling 1,0,1,0... in RUN -> GEN_EN mirrors IL_VALID, exactly 4 accepts, SCC_DONE after the 4th.
REQ-034 START with E_LEN=0 -> stays IDLE, no GEN_INIT; START during RUN -> ignored, count unaffected.
REQ-035 RST_SCC=1 after 3 of 10 bits -> next cycle all outputs 0, IDLE; new START runs full 10 bits.
REQ-036 SCC_TIMEOUT_EN defined, GOLD_VALID held 0 -> SCC_ERR pulse after 2047 WARMUP cycles, IDLE; undefined -> remains WARMUP, SCC_ERR 0.
REQ-037 E_LEN=65535, both valids constant 1 -> SCC_DONE exactly 65535 accept cycles after RUN entry.
